// File: rtl/monopix_core.sv
// Monopix-style pixel matrix core: per-pixel hit capture with leading/trailing
// timestamps, freeze-gated readout queue and a 27-bit serial read port.
// Build option: define MONOPIX_GRAY_TS_EN for gray-coded timestamps
// (binary timestamps otherwise).
module monopix_core #(
  parameter int unsigned N_COL = 8,
  parameter int unsigned N_ROW = 16
) (
  input  logic                   CLK_BX_PAD,
  input  logic                   RESET_BCID_PAD,
  input  logic [N_COL*N_ROW-1:0] ANA_HIT,
  input  logic                   PULSE_PAD,
  input  logic [N_COL*N_ROW-1:0] INJ_EN,
  input  logic                   FREEZE_PAD,
  input  logic                   READ_PAD,
  output logic                   TOKEN_PAD,
  output logic                   OUT_PAD,
  output logic                   HIT_OR_PAD
);

  localparam int unsigned NPix = N_COL * N_ROW;

  typedef enum logic [1:0] {StIdle, StBusy, StDone, StPend} pix_state_e;

  logic [NPix-1:0] hit, hit_q, hit_rise, hit_fall;
  logic [NPix-1:0] pend, pend_first, pend_d, grant;
  logic            reset_q;
  logic [5:0]      bcid_q, ts;
  logic            read_q, read_edge;
  logic [26:0]     sr_q, word;
  logic            token_q, hit_or_q;

  // OR-accumulated readout word contributions, one stage per pixel
  logic [NPix:0][26:0] word_acc;

  assign hit       = ANA_HIT | ({NPix{PULSE_PAD}} & INJ_EN);
  // The cycle right after reset has a cleared hit history; a hit held through
  // reset must not look like a fresh rising edge.
  assign hit_rise  = hit & ~hit_q & {NPix{~reset_q}};
  assign hit_fall  = ~hit & hit_q;
  assign read_edge = READ_PAD & ~read_q;

`ifdef MONOPIX_GRAY_TS_EN
  assign ts = bcid_q ^ (bcid_q >> 1);
`else
  assign ts = bcid_q;
`endif

  // Lowest set index is lowest column, then lowest row
  assign pend_first  = pend & (~pend + NPix'(1));
  assign word_acc[0] = '0;
  assign word        = word_acc[NPix];

  for (genvar g = 0; g < int'(NPix); g++) begin : g_pix
    localparam logic [5:0] Col = 6'(g / int'(N_ROW));
    localparam logic [8:0] Row = 9'(g % int'(N_ROW));

    pix_state_e state_q;
    logic [5:0] le_q, te_q;

    assign pend[g]  = (state_q == StPend);
    assign grant[g] = read_edge & pend_first[g];
    // Next-cycle pending flag, so the token reflects reads and promotions at once
    assign pend_d[g] = (pend[g] & ~grant[g]) | ((state_q == StDone) & ~FREEZE_PAD);
    assign word_acc[g+1] = word_acc[g] | (pend_first[g] ? {Col, te_q, le_q, Row} : 27'd0);

    // Pixel state machine with timestamp latches
    always_ff @(posedge CLK_BX_PAD) begin
      if (RESET_BCID_PAD) begin
        state_q <= StIdle;
        le_q    <= '0;
        te_q    <= '0;
      end else begin
        case (state_q)
          StIdle: if (hit_rise[g]) begin
            le_q    <= ts;
            state_q <= StBusy;
          end
          StBusy: if (hit_fall[g]) begin
            te_q    <= ts;
            state_q <= StDone;
          end
          StDone: if (!FREEZE_PAD) state_q <= StPend;
          StPend: if (grant[g]) state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Bunch counter, hit/read history and registered status outputs
  always_ff @(posedge CLK_BX_PAD) begin
    if (RESET_BCID_PAD) begin
      bcid_q   <= '0;
      hit_q    <= '0;
      reset_q  <= 1'b1;
      read_q   <= 1'b0;
      token_q  <= 1'b0;
      hit_or_q <= 1'b0;
    end else begin
      bcid_q   <= bcid_q + 6'd1;
      hit_q    <= hit;
      reset_q  <= 1'b0;
      read_q   <= READ_PAD;
      token_q  <= |pend_d;
      hit_or_q <= |hit;
    end
  end

  // Serializer: load on read edge (zero word when nothing pending), else shift MSB out
  always_ff @(posedge CLK_BX_PAD) begin
    if (RESET_BCID_PAD) begin
      sr_q <= '0;
    end else if (read_edge) begin
      sr_q <= word;
    end else begin
      sr_q <= {sr_q[25:0], 1'b0};
    end
  end

  assign TOKEN_PAD  = token_q;
  assign OUT_PAD    = sr_q[26];
  assign HIT_OR_PAD = hit_or_q;

endmodule

// File: tb/tb_monopix_core.sv
// Self-checking bench for monopix_core: scoreboarded serial readout plus
// inline checks of token, hit-or and reset behaviour.
module tb_monopix_core;

  localparam int NC = 8;
  localparam int NR = 16;
  localparam int NP = NC * NR;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NP-1:0] ana = '0;
  logic [NP-1:0] inj = '0;
  logic          pulse = 1'b0;
  logic          freeze = 1'b0;
  logic          rd = 1'b0;
  logic          token, outp, hitor;

  logic [5:0]  bcid_m;
  logic [26:0] exp_q[$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  // Reference bunch counter: value seen by the DUT during the current cycle
  always @(posedge clk) bcid_m <= rst ? 6'd0 : bcid_m + 6'd1;

  monopix_core #(.N_COL(NC), .N_ROW(NR)) dut (
    .CLK_BX_PAD    (clk),
    .RESET_BCID_PAD(rst),
    .ANA_HIT       (ana),
    .PULSE_PAD     (pulse),
    .INJ_EN        (inj),
    .FREEZE_PAD    (freeze),
    .READ_PAD      (rd),
    .TOKEN_PAD     (token),
    .OUT_PAD       (outp),
    .HIT_OR_PAD    (hitor)
  );

  function automatic logic [5:0] tsf(input logic [5:0] b);
`ifdef MONOPIX_GRAY_TS_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  function automatic logic [26:0] mkword(input int col, input logic [5:0] te,
                                         input logic [5:0] le, input int row);
    return {6'(col), te, le, 9'(row)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ana = '0; inj = '0; pulse = 1'b0; freeze = 1'b0; rd = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_bcid(input logic [5:0] v);
    int n = 0;
    while (bcid_m !== v && n < 140) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bcid_m !== v) begin
      bad++;
      $display("FAIL wait_bcid: got %0d required %0d", bcid_m, v);
    end
  endtask

  task automatic hit_pix(input int idx, input int len, output logic [5:0] le,
                         output logic [5:0] te);
    @(negedge clk);
    ana[idx] = 1'b1;
    le = bcid_m;
    repeat (len) @(negedge clk);
    ana[idx] = 1'b0;
    te = bcid_m;
    repeat (2) @(negedge clk);
  endtask

  // Pulse READ, shift in nbits and compare them against the next scoreboard word
  task automatic do_read(input int nbits, input string name);
    logic [26:0] w, e, m;
    w = '0;
    @(negedge clk);
    rd = 1'b1;
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk);
      if (k == 0) rd = 1'b0;
      w[26-k] = outp;
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: got %h but scoreboard empty", name, w);
    end else begin
      e = exp_q.pop_front();
      m = 27'((64'h1 << 27) - (64'h1 << (27 - nbits)));
      if ((w & m) !== (e & m)) begin
        bad++;
        $display("FAIL %s: word got %h required %h (mask %h)", name, w, e, m);
      end
    end
    if (nbits == 27) begin
      @(negedge clk);
      total++;
      if (outp !== 1'b0) begin
        bad++;
        $display("FAIL %s_hold0: out got %b required 0", name, outp);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; ana = '1; rd = 1'b1;
    repeat (2) @(negedge clk);
    total += 3;
    if (token !== 1'b0) begin bad++; $display("FAIL reset_token: got %b required 0", token); end
    if (outp !== 1'b0) begin bad++; $display("FAIL reset_out: got %b required 0", outp); end
    if (hitor !== 1'b0) begin bad++; $display("FAIL reset_hitor: got %b required 0", hitor); end
    ana = '0; rd = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    wait_bcid(6'd5);
    ana[0] = 1'b1;
    wait_bcid(6'd10);
    ana[0] = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (token !== 1'b1) begin bad++; $display("FAIL single_token_pre: got %b required 1", token); end
    exp_q.push_back(mkword(0, tsf(6'd10), tsf(6'd5), 0));
    do_read(27, "single_word");
    total++;
    if (token !== 1'b0) begin bad++; $display("FAIL single_token_post: got %b required 0", token); end
  endtask

  task automatic test_two_reads();
    logic [5:0] le0, te0, le1, te1;
    do_reset();
    hit_pix(2 * NR + 15, 3, le1, te1);
    hit_pix(0, 2, le0, te0);
    exp_q.push_back(mkword(0, tsf(te0), tsf(le0), 0));
    exp_q.push_back(mkword(2, tsf(te1), tsf(le1), 15));
    do_read(27, "two_first");
    total++;
    if (token !== 1'b1) begin bad++; $display("FAIL two_token_mid: got %b required 1", token); end
    do_read(27, "two_second");
    total++;
    if (token !== 1'b0) begin bad++; $display("FAIL two_token_end: got %b required 0", token); end
  endtask

  task automatic test_freeze();
    logic [5:0] le, te;
    do_reset();
    freeze = 1'b1;
    hit_pix(1 * NR + 3, 2, le, te);
    repeat (3) @(negedge clk);
    total++;
    if (token !== 1'b0) begin bad++; $display("FAIL freeze_token: got %b required 0", token); end
    exp_q.push_back(27'd0);
    do_read(27, "freeze_empty");
    freeze = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (token !== 1'b1) begin bad++; $display("FAIL unfreeze_token: got %b required 1", token); end
    exp_q.push_back(mkword(1, tsf(te), tsf(le), 3));
    do_read(27, "unfreeze_word");
  endtask

  task automatic test_inject();
    logic [5:0] b;
    do_reset();
    inj[5] = 1'b1;
    @(negedge clk);
    total++;
    if (hitor !== 1'b0) begin bad++; $display("FAIL inj_hitor_pre: got %b required 0", hitor); end
    pulse = 1'b1;
    b = bcid_m;
    @(negedge clk);
    total++;
    if (hitor !== 1'b1) begin bad++; $display("FAIL inj_hitor: got %b required 1", hitor); end
    repeat (3) @(negedge clk);
    pulse = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (token !== 1'b1) begin bad++; $display("FAIL inj_token: got %b required 1", token); end
    exp_q.push_back(mkword(0, tsf(b + 6'd4), tsf(b), 5));
    do_read(27, "inj_word");
    inj = '0;
  endtask

  task automatic test_wrap();
    logic [5:0] le_exp;
`ifdef MONOPIX_GRAY_TS_EN
    le_exp = 6'd32;
`else
    le_exp = 6'd63;
`endif
    do_reset();
    wait_bcid(6'd63);
    ana[3 * NR] = 1'b1;
    wait_bcid(6'd1);
    ana[3 * NR] = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back(mkword(3, 6'd1, le_exp, 0));
    do_read(27, "wrap_word");
  endtask

  task automatic test_back_to_back();
    logic [5:0] lea, tea, leb, teb;
    do_reset();
    hit_pix(4 * NR + 6, 2, lea, tea);
    hit_pix(2 * NR + 1, 3, leb, teb);
    exp_q.push_back(mkword(2, tsf(teb), tsf(leb), 1));
    do_read(5, "b2b_partial");
    exp_q.push_back(mkword(4, tsf(tea), tsf(lea), 6));
    do_read(27, "b2b_next");
    total++;
    if (token !== 1'b0) begin bad++; $display("FAIL b2b_token: got %b required 0", token); end
  endtask

  task automatic test_reset_mid();
    logic [5:0] le, te;
    do_reset();
    ana[7] = 1'b1;
    hit_pix(4 * NR + 2, 2, le, te);
    hit_pix(5 * NR + 1, 2, le, te);
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total += 2;
    if (outp !== 1'b0) begin bad++; $display("FAIL midrst_out: got %b required 0", outp); end
    if (token !== 1'b0) begin bad++; $display("FAIL midrst_token: got %b required 0", token); end
    rst = 1'b0;
    // Pixel 7 was held high through reset; dropping it must not complete a hit
    @(negedge clk);
    ana[7] = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (token !== 1'b0) begin bad++; $display("FAIL midrst_token_after: got %b required 0", token); end
    exp_q.push_back(27'd0);
    do_read(27, "midrst_empty");
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_reads();
    test_freeze();
    test_inject();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: got %0d words required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/monopix_core.md
MONOPIX_CORE -- requirements
Module: monopix_core

Interface
REQ-001 SHALL have a single clock CLK_BX_PAD; all logic is rising-edge triggered on it.
REQ-002 SHALL have RESET_BCID_PAD, which is synchronous and active-high.
REQ-003 Parameters SHALL be:
- N_COL, default 8, number of columns (max 64);
- N_ROW, default 16, number of rows (max 512).
Pixel index i = col*N_ROW + row.
REQ-004 Ports SHALL be:
- CLK_BX_PAD  in  1  clock;
- RESET_BCID_PAD  in  1  sync active-high reset;
- ANA_HIT  in  N_COL*N_ROW  per-pixel discriminator outputs, synchronous to the clock;
- PULSE_PAD  in  1  injection pulse;
- INJ_EN  in  N_COL*N_ROW  per-pixel injection enable;
- FREEZE_PAD  in  1  freeze the readable pixel set;
- READ_PAD  in  1  read request, acted on at its rising edge;
- TOKEN_PAD  out  1  at least one pixel readable;
- OUT_PAD  out  1  serial data, MSB first;
- HIT_OR_PAD  out  1  registered OR of all effective hits.

Function
REQ-005 Effective hit SHALL be h[i] = ANA_HIT[i] | (PULSE_PAD & INJ_EN[i]); the previous-cycle value of h[i] SHALL be registered.
REQ-006 Timestamp SHALL be a 6-bit binary counter BCID, +1 per cycle, wrapping 63->0; ts = gray(BCID) or binary per REQ-019.
REQ-007 Each pixel SHALL be in one of four states: IDLE, BUSY, DONE, PEND.
- IDLE: on a rising h, latch LE=ts and go BUSY.
- BUSY: on a falling h, latch TE=ts and go DONE.
- DONE: go PEND on any cycle with FREEZE_PAD=0.
- PEND: go IDLE when read.
REQ-008 Hit edges in DONE or PEND SHALL be ignored (pixel is dead until read); a pixel that is BUSY ignores further rising edges.
REQ-009 TOKEN_PAD SHALL be the registered OR of the PEND flags (1 cycle latency) and SHALL account for a PEND flag cleared in the same cycle.
REQ-010 Read rising edge SHALL be READ_PAD=1 with the previous-cycle READ_PAD=0. At it, the DUT SHALL:
- select the PEND pixel with the lowest col, ties broken by lowest row;
- load the 27-bit word {col[5:0], TE[5:0], LE[5:0], row[8:0]};
- set that pixel to IDLE.
REQ-011 With no PEND pixel at a read rising edge, the DUT SHALL load an all-zero word and change no pixel state.
REQ-012 OUT_PAD SHALL present word bit 26 in the cycle after the load edge, then one bit per cycle down to bit 0, then hold 0.
REQ-013 A new read rising edge during shifting SHALL abort the current word and load the next word.
REQ-014 A pixel selected in a cycle where its DONE->PEND transition also occurs SHALL NOT be read; only flags that were already PEND count.
REQ-015 HIT_OR_PAD SHALL be the registered OR of h[] (1 cycle latency).

Reset
REQ-016 While RESET_BCID_PAD=1 at a clock edge, the DUT SHALL:
- set BCID to 0;
- set all pixels to IDLE with LE=TE=0;
- clear the previous-hit and previous-READ registers;
- clear the shift register;
- set TOKEN_PAD, OUT_PAD and HIT_OR_PAD to 0.
REQ-017 Reset SHALL override all other activity, including mid-shift and mid-hit; pixels whose hit is still high after reset see a rising edge only once h goes low and then high again.
REQ-018 The first BCID increment SHALL occur at the first edge with reset low; BCID=1 after it.

Configuration
REQ-019 The macro MONOPIX_GRAY_TS_EN SHALL select the timestamp coding:
- defined: ts = BCID ^ (BCID >> 1) (gray code);
- undefined: ts = BCID (binary).
All other behaviour is identical in both cases.

Verification
REQ-020 Reset, then drive ANA_HIT[0] high while BCID=5 and low while BCID=10, then pulse READ_PAD -> TOKEN_PAD=1 before the read; the serialized word is col=0, TE=15, LE=7, row=0 (binary build: TE=10, LE=5); TOKEN_PAD=0 afterwards.
REQ-021 Complete hits on pixel (2,15) and pixel (0,0), then issue two reads -> the first word has col=0,row=0 and the second has col=2,row=15; TOKEN_PAD stays 1 between the reads and is 0 after the second.
REQ-022 With FREEZE_PAD=1, complete a hit on pixel (1,3) -> TOKEN_PAD stays 0 and a read returns the all-zero word; after FREEZE_PAD=0, TOKEN_PAD rises and the next read returns col=1,row=3.
REQ-023 Set INJ_EN[5]=1 and hold PULSE_PAD high for 4 cycles -> HIT_OR_PAD goes high 1 cycle after PULSE_PAD; pixel (0,5) becomes PEND with TE-LE=4 in binary coding.
REQ-024 Give a hit its rising edge at BCID=63 and its falling edge at BCID=1 -> gray build: LE=32, TE=1; binary build: LE=63, TE=1.
REQ-025 Assert reset in the middle of shifting a word -> OUT_PAD=0 and TOKEN_PAD=0 on the next cycle; no pixel remains PEND.
